hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_i  input  1  asynchronous reset, active-low.
REQ-003 SHALL provide: id_valid_i  input  1  ID stage holds a real instruction.
REQ-004 SHALL provide: id_rsaddr_i / id_rtaddr_i  input  5 each  source register addresses of the ID instruction.
REQ-005 SHALL provide: id_rs_used_i / id_rt_used_i  input  1 each  the ID instruction reads rs / rt.
REQ-006 SHALL provide: id_wraddr_i  input  5  destination register of the ID instruction.
REQ-007 SHALL provide: id_regwrite_i / id_memread_i  input  1 each  the ID instruction writes the register file / is a load.
REQ-008 SHALL provide: branch_taken_i  input  1  branch resolved taken in ID.
REQ-009 SHALL provide: mem_ready_i  input  1  data memory completes the access in MEM this cycle.
REQ-010 SHALL provide: stall_o  output  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-011 SHALL provide: freeze_o  output  1  hold all pipeline registers.
REQ-012 SHALL provide: flush_o  output  1  clear IF/ID.
REQ-013 SHALL provide: state_o  output  2  FSM state (00 RUN, 01 LOAD_STALL, 10 MEM_WAIT).

Function
REQ-014 SHALL track three shadow entries, EX, MEM and WB, each holding {valid, wraddr[4:0], regwrite, memread}.
REQ-015 SHALL, when freeze_o=0, shift the entries on each edge: ID->EX, EX->MEM, MEM->WB; WB is discarded.
REQ-016 SHALL load EX with an invalid bubble when stall_o=1, flush_o=1 or id_valid_i=0.
REQ-017 SHALL hold all entries unchanged while freeze_o=1.
REQ-018 SHALL compute the load-use hit combinationally: EX.valid & EX.memread & EX.regwrite & EX.wraddr!=0 & id_valid_i & ((id_rs_used_i & rsaddr==EX.wraddr) | (id_rt_used_i & rtaddr==EX.wraddr)).
REQ-019 SHALL compute the memory wait combinationally: MEM.valid & MEM.memread & ~mem_ready_i.
REQ-020 SHALL drive freeze_o = memory wait, stall_o = load-use hit & ~freeze_o, and flush_o = branch_taken_i & id_valid_i & ~stall_o & ~freeze_o.
REQ-021 SHALL make freeze_o take priority over stall_o, and stall_o over flush_o; a deferred branch is re-evaluated on the following cycle.
REQ-022 SHALL move the FSM from RUN to LOAD_STALL on a load-use hit, and from RUN to MEM_WAIT on a memory wait.
REQ-023 SHALL return the FSM from LOAD_STALL to RUN after exactly one cycle; a load-use stall lasts one cycle, the consumer then takes MEM/WB forwarding.
REQ-024 SHALL hold the FSM in MEM_WAIT while mem_ready_i=0 and return it to RUN on the edge where mem_ready_i=1.
REQ-025 SHALL, in MEM_WAIT, hold any pending load-use condition and re-evaluate it after the freeze releases.
REQ-026 SHALL never stall on register 0, and SHALL never stall on a non-load producer in EX, on a producer in MEM or WB, or on a field with its *_used_i low.
REQ-027 SHALL keep all outputs glitch-free in the sense that they are functions of registered state and current inputs only, with no combinational loops.

Reset
REQ-028 SHALL, on rst_i=0 and independent of clk_i, clear all entry valid bits, set the FSM to RUN, and drive stall_o, freeze_o and flush_o to 0.
REQ-029 SHALL abandon any stall or wait that is in progress when reset is asserted mid-operation; after release the first edge is treated as RUN.

Configuration
REQ-030 SHALL, with HAZARD_PERF_EN defined, add the outputs stall_cnt_o[31:0] and freeze_cnt_o[31:0].
REQ-031 SHALL, with HAZARD_PERF_EN defined, increment stall_cnt_o on each cycle with stall_o=1 and freeze_cnt_o on each cycle with freeze_o=1, wrap at 2^32, and clear both on reset.
REQ-032 SHALL, without HAZARD_PERF_EN, omit both counter ports and their logic, with the remaining behaviour identical.

Verification
REQ-033 SHALL cover the load-use case: lw $3 then add $4,$3,$5 -> stall_o=1 for exactly 1 cycle, EX bubble, state_o 00->01->00.
REQ-034 SHALL cover the non-load producer: add $3 then sub $6,$3,$1 -> stall_o never asserted.
REQ-035 SHALL cover register 0: lw $0 then add $4,$0,$0 -> no stall.
REQ-036 SHALL cover the memory wait: lw reaches MEM with mem_ready_i=0 for 3 cycles -> freeze_o=1 for 3 cycles, state_o=10, all entries held; release on ready -> RUN.
REQ-037 SHALL cover simultaneous events: load-use hit and branch_taken_i=1 in the same cycle -> stall_o=1, flush_o=0; the next cycle gives flush_o=1.
REQ-038 SHALL cover reset: rst_i driven low during MEM_WAIT -> freeze_o=0 immediately, state_o=00, and (with HAZARD_PERF_EN) counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Pipeline hazard controller for a 5-stage in-order core. It keeps a small
//   shadow copy of the destination information of the instructions in EX,
//   MEM and WB, and from it derives the load-use stall, the data-memory
//   freeze and the branch flush for the front end.
//
//   Optional feature: define HAZARD_PERF_EN to add the stall / freeze
//   cycle counters (stall_cnt_o, freeze_cnt_o).
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active low
//   id_valid_i       ID holds a real instruction
//   id_rsaddr_i      rs address of the ID instruction
//   id_rtaddr_i      rt address of the ID instruction
//   id_rs_used_i     ID instruction reads rs
//   id_rt_used_i     ID instruction reads rt
//   id_wraddr_i      destination of the ID instruction
//   id_regwrite_i    ID instruction writes the register file
//   id_memread_i     ID instruction is a load
//   branch_taken_i   branch resolved taken in ID
//   mem_ready_i      data memory completes the MEM access this cycle
//   stall_cnt_o      cycles with stall_o=1 (HAZARD_PERF_EN only)
//   freeze_cnt_o     cycles with freeze_o=1 (HAZARD_PERF_EN only)
//   stall_o          hold PC and IF/ID, bubble into ID/EX
//   freeze_o         hold every pipeline register
//   flush_o          clear IF/ID
//   state_o          00 RUN, 01 LOAD_STALL, 10 MEM_WAIT
module hazard_scoreboard (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rsaddr_i,
    input  logic [4:0]  id_rtaddr_i,
    input  logic        id_rs_used_i,
    input  logic        id_rt_used_i,
    input  logic [4:0]  id_wraddr_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic        branch_taken_i,
    input  logic        mem_ready_i,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] freeze_cnt_o,
`endif
    output logic        stall_o,
    output logic        freeze_o,
    output logic        flush_o,
    output logic [1:0]  state_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] wraddr;
        logic       regwrite;
        logic       memread;
    } entry_t;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

    entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t state_q, state_d;

    logic lu_hit, mem_wait;
    logic rs_match, rt_match;

    // WB has no consumer inside this block; it is tracked so the shadow
    // pipeline mirrors the real one for forwarding/debug taps.
    logic wb_unused;
    assign wb_unused = ^wb_q;

    // Hazard detection: pure functions of registered entries and current
    // inputs, so no combinational path loops back through the outputs.
    assign rs_match = id_rs_used_i & (id_rsaddr_i == ex_q.wraddr);
    assign rt_match = id_rt_used_i & (id_rtaddr_i == ex_q.wraddr);
    assign lu_hit   = ex_q.valid & ex_q.memread & ex_q.regwrite
                    & (ex_q.wraddr != 5'd0) & id_valid_i
                    & (rs_match | rt_match);
    assign mem_wait = mem_q.valid & mem_q.memread & ~mem_ready_i;

    // Priority: freeze > stall > flush. A branch masked by a stall is seen
    // again next cycle because IF/ID is held with the branch still in ID.
    assign freeze_o = mem_wait;
    assign stall_o  = lu_hit & ~freeze_o;
    assign flush_o  = branch_taken_i & id_valid_i & ~stall_o & ~freeze_o;
    assign state_o  = state_q;

    // Shadow pipeline advance
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze_o) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (stall_o || flush_o || !id_valid_i) begin
                ex_d = '0;
            end else begin
                ex_d = '{valid:    1'b1,
                         wraddr:   id_wraddr_i,
                         regwrite: id_regwrite_i,
                         memread:  id_memread_i};
            end
        end
    end

    // FSM next state. A freeze pending while in LOAD_STALL (the load just
    // moved into MEM) goes straight to MEM_WAIT. In MEM_WAIT the load is
    // held in MEM, so mem_ready_i alone decides release; a load-use hit
    // still pending is re-evaluated from RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait)    state_d = MEM_WAIT;
                else if (lu_hit) state_d = LOAD_STALL;
            end
            LOAD_STALL: state_d = mem_wait ? MEM_WAIT : RUN;
            MEM_WAIT:   state_d = mem_ready_i ? RUN : MEM_WAIT;
            default:    state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, freeze_cnt_q;

    // Free-running, wraps at 2^32
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= 32'd0;
            freeze_cnt_q <= 32'd0;
        end else begin
            if (stall_o)  stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (freeze_o) freeze_cnt_q <= freeze_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed pipeline scenarios plus random
// traffic, checked against an instruction-level pipeline model. Expected
// outputs are queued by the driver and popped by an independent monitor.
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rsaddr_i, id_rtaddr_i, id_wraddr_i;
    logic        id_rs_used_i, id_rt_used_i, id_regwrite_i, id_memread_i;
    logic        branch_taken_i, mem_ready_i;
    logic        stall_o, freeze_o, flush_o;
    logic [1:0]  state_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_o, freeze_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    hazard_scoreboard dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rsaddr_i(id_rsaddr_i), .id_rtaddr_i(id_rtaddr_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_wraddr_i(id_wraddr_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .branch_taken_i(branch_taken_i),
        .mem_ready_i(mem_ready_i),
`ifdef HAZARD_PERF_EN
        .stall_cnt_o(stall_cnt_o), .freeze_cnt_o(freeze_cnt_o),
`endif
        .stall_o(stall_o), .freeze_o(freeze_o), .flush_o(flush_o),
        .state_o(state_o)
    );

    typedef struct {
        logic v; logic [4:0] rs, rt; logic rsu, rtu;
        logic [4:0] wa; logic rw, mr;
    } instr_t;
    typedef struct { logic v; logic [4:0] wa; logic rw, mr; } ment_t;
    typedef struct { logic stall, freeze, flush; logic [1:0] st; } exp_t;

    int total = 0, bad = 0;
    exp_t exp_q[$];

    // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
    ment_t pipe[$];
    int    mst;              // 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT
    int    n_stall, n_freeze;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic instr_t nop();
        instr_t i = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
        return i;
    endfunction
    function automatic instr_t lw(logic [4:0] d);
        instr_t i = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, d, 1'b1, 1'b1};
        return i;
    endfunction
    function automatic instr_t alu(logic [4:0] d, logic [4:0] s, logic [4:0] t);
        instr_t i = '{1'b1, s, t, 1'b1, 1'b1, d, 1'b1, 1'b0};
        return i;
    endfunction

    task automatic model_reset();
        ment_t b = '{1'b0, 5'd0, 1'b0, 1'b0};
        pipe.delete();
        repeat (3) pipe.push_back(b);
        mst = 0; n_stall = 0; n_freeze = 0;
    endtask

    // One ID-stage cycle: drive, predict, advance the model
    task automatic drive(instr_t i, logic br, logic rdy);
        ment_t ex, mem, nw;
        bit hit, mw;
        exp_t e;
        @(negedge clk_i);
        id_valid_i = i.v; id_rsaddr_i = i.rs; id_rtaddr_i = i.rt;
        id_rs_used_i = i.rsu; id_rt_used_i = i.rtu; id_wraddr_i = i.wa;
        id_regwrite_i = i.rw; id_memread_i = i.mr;
        branch_taken_i = br; mem_ready_i = rdy;
        #1;
        ex = pipe[0]; mem = pipe[1];
        hit = ex.v && ex.mr && ex.rw && ex.wa != 0 && i.v &&
              ((i.rsu && i.rs == ex.wa) || (i.rtu && i.rt == ex.wa));
        mw  = mem.v && mem.mr && !rdy;
        e.freeze = mw;
        e.stall  = hit && !mw;
        e.flush  = br && i.v && !e.stall && !mw;
        e.st     = 2'(mst);
        exp_q.push_back(e);
        if (e.stall) n_stall++;
        if (mw)      n_freeze++;
        if (!mw) begin
            if (e.stall || e.flush || !i.v) nw = '{1'b0, 5'd0, 1'b0, 1'b0};
            else                            nw = '{1'b1, i.wa, i.rw, i.mr};
            void'(pipe.pop_back());
            pipe.push_front(nw);
        end
        case (mst)
            0:       mst = mw ? 2 : (hit ? 1 : 0);
            1:       mst = mw ? 2 : 0;
            default: mst = rdy ? 0 : 2;
        endcase
    endtask

    // Monitor: outputs are valid every cycle; compare after the driver pushed
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_o",  32'(stall_o),  32'(e.stall));
                check("freeze_o", 32'(freeze_o), 32'(e.freeze));
                check("flush_o",  32'(flush_o),  32'(e.flush));
                check("state_o",  32'(state_o),  32'(e.st));
            end
        end
    end

    task automatic zero_inputs();
        id_valid_i = 0; id_rsaddr_i = 0; id_rtaddr_i = 0; id_rs_used_i = 0;
        id_rt_used_i = 0; id_wraddr_i = 0; id_regwrite_i = 0;
        id_memread_i = 0; branch_taken_i = 0; mem_ready_i = 1;
    endtask

    initial begin
        instr_t r;
        rst_i = 1'b0;
        zero_inputs();
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_stall",  32'(stall_o),  0);
        check("rst_freeze", 32'(freeze_o), 0);
        check("rst_flush",  32'(flush_o),  0);
        check("rst_state",  32'(state_o),  0);
        rst_i = 1'b1;

        // load-use: lw $3 ; add $4,$3,$5 (held one cycle by the stall)
        drive(lw(5'd3), 0, 1);
        drive(alu(5'd4, 5'd3, 5'd5), 0, 1);
        drive(alu(5'd4, 5'd3, 5'd5), 0, 1);
        repeat (3) drive(nop(), 0, 1);
        // non-load producer
        drive(alu(5'd3, 5'd2, 5'd2), 0, 1);
        drive(alu(5'd6, 5'd3, 5'd1), 0, 1);
        repeat (3) drive(nop(), 0, 1);
        // register 0
        drive(lw(5'd0), 0, 1);
        drive(alu(5'd4, 5'd0, 5'd0), 0, 1);
        repeat (3) drive(nop(), 0, 1);
        // memory wait: 3 cycles not ready once the load reaches MEM
        drive(lw(5'd7), 0, 1);
        drive(alu(5'd8, 5'd1, 5'd2), 0, 1);
        repeat (3) drive(alu(5'd9, 5'd7, 5'd1), 0, 0);
        drive(alu(5'd9, 5'd7, 5'd1), 0, 1);
        repeat (3) drive(nop(), 0, 1);
        // load-use and taken branch together
        drive(lw(5'd3), 0, 1);
        drive(alu(5'd4, 5'd3, 5'd5), 1, 1);
        drive(alu(5'd4, 5'd3, 5'd5), 1, 1);
        repeat (3) drive(nop(), 0, 1);
        // reset in the middle of MEM_WAIT
        drive(lw(5'd7), 0, 1);
        drive(nop(), 0, 1);
        drive(nop(), 0, 0);
        drive(nop(), 0, 0);          // state is MEM_WAIT here
        #2;
        check("pre_rst_freeze", 32'(freeze_o), 1);
        rst_i = 1'b0;
        #1;
        check("mid_rst_freeze", 32'(freeze_o), 0);
        check("mid_rst_state",  32'(state_o),  0);
        check("mid_rst_stall",  32'(stall_o),  0);
`ifdef HAZARD_PERF_EN
        check("mid_rst_scnt", stall_cnt_o,  0);
        check("mid_rst_fcnt", freeze_cnt_o, 0);
`endif
        zero_inputs();
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(lw(5'd5), 0, 1);
        drive(alu(5'd6, 5'd1, 5'd5), 0, 1);
        drive(alu(5'd6, 5'd1, 5'd5), 0, 1);

        // Random traffic: narrow register range to make hazards frequent
        for (int n = 0; n < 3000; n++) begin
            r.v   = ($urandom_range(0, 9) != 0);
            r.rs  = 5'($urandom_range(0, 3));
            r.rt  = 5'($urandom_range(0, 3));
            r.rsu = $urandom_range(0, 3) != 0;
            r.rtu = $urandom_range(0, 1) != 0;
            r.wa  = 5'($urandom_range(0, 3));
            r.rw  = $urandom_range(0, 4) != 0;
            r.mr  = $urandom_range(0, 2) == 0;
            drive(r, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        end

        @(negedge clk_i);
        #3;
        check("queue_drained", 32'(exp_q.size()), 0);
`ifdef HAZARD_PERF_EN
        check("stall_cnt",  stall_cnt_o,  32'(n_stall));
        check("freeze_cnt", freeze_cnt_o, 32'(n_freeze));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
